// File: rtl/ex_mem_pipe_reg_pkg.sv
// Shared definitions for the EX->MEM pipeline stage: result-select encodings,
// default datapath widths and the stage occupancy states.
package ex_mem_pipe_reg_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int RADDR_W_DEF  = 5;
    localparam int LS_W_DEF     = 3;
    localparam int SS_W_DEF     = 2;
    localparam int LINK_REG     = 31;
    localparam int LINK_OFF_DEF = 4;

    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_LO   = 2'b01,
        RES_HI   = 2'b10,
        RES_LINK = 2'b11
    } res_sel_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } pipe_state_e;

endpackage

// File: rtl/ex_mem_result_sel.sv
// EX-side result and destination formation, evaluated on the incoming
// instruction before it is captured into the stage.
module ex_mem_result_sel
    import ex_mem_pipe_reg_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int RADDR_W  = RADDR_W_DEF,
    parameter int LINK_DST = LINK_REG,
    parameter int LINK_OFF = LINK_OFF_DEF
) (
    input  logic [1:0]         i_res_sel,
    input  logic               i_link_ra,
    input  logic [DATA_W-1:0]  i_pc4,
    input  logic [DATA_W-1:0]  i_alu,
    input  logic [DATA_W-1:0]  i_hi,
    input  logic [DATA_W-1:0]  i_lo,
    input  logic [RADDR_W-1:0] i_dst,
    output logic [DATA_W-1:0]  o_result,
    output logic [RADDR_W-1:0] o_dst
);

    always_comb begin
        o_result = i_alu;
        case (res_sel_e'(i_res_sel))
            RES_ALU:  o_result = i_alu;
            RES_LO:   o_result = i_lo;
            RES_HI:   o_result = i_hi;
            // link value wraps modulo 2^DATA_W
            RES_LINK: o_result = i_pc4 + DATA_W'(LINK_OFF);
            default:  o_result = i_alu;
        endcase
    end

    always_comb begin
        o_dst = i_dst;
        if (i_link_ra) begin
            o_dst = RADDR_W'(LINK_DST);
        end
    end

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// EX->MEM pipeline register with a registered-ready skid entry, so MEM
// back-pressure never reaches EX combinationally.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_EMPTY | no entry held, outputs invalid
// ST_ONE   | main entry valid and driving outputs
// ST_FULL  | main and skid valid, InReady low
module ex_mem_pipe_reg
    import ex_mem_pipe_reg_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int RADDR_W  = RADDR_W_DEF,
    parameter int LS_W     = LS_W_DEF,
    parameter int SS_W     = SS_W_DEF,
    parameter int LINK_DST = LINK_REG,
    parameter int LINK_OFF = LINK_OFF_DEF
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               Flush,
    input  logic               InValid,
    output logic               InReady,
    input  logic               RegWriteE,
    input  logic               MemtoRegE,
    input  logic               MemWriteE,
    input  logic [1:0]         ResSelE,
    input  logic               LinkRaE,
    input  logic [DATA_W-1:0]  PC4E,
    input  logic [DATA_W-1:0]  ALUResultE,
    input  logic [DATA_W-1:0]  ExMidE,
    input  logic [RADDR_W-1:0] ExDstE,
    input  logic [LS_W-1:0]    LsE,
    input  logic [SS_W-1:0]    SsE,
    input  logic [DATA_W-1:0]  HiE,
    input  logic [DATA_W-1:0]  LoE,
    output logic               OutValid,
    input  logic               OutReady,
    output logic               RegWriteM,
    output logic               MemtoRegM,
    output logic               MemWriteM,
    output logic [DATA_W-1:0]  ResultM,
    output logic [DATA_W-1:0]  ExMidM,
    output logic [RADDR_W-1:0] ExDstM,
    output logic [LS_W-1:0]    LsM,
    output logic [SS_W-1:0]    SsM,
    output logic [DATA_W-1:0]  PC4M
);

    localparam int PAY_W = 3 + 3 * DATA_W + RADDR_W + LS_W + SS_W;

    pipe_state_e        r_state;
    pipe_state_e        w_state_nxt;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [PAY_W-1:0]   r_main;
    logic [PAY_W-1:0]   r_skid;

    logic [DATA_W-1:0]  w_result;
    logic [RADDR_W-1:0] w_dst;
    logic [PAY_W-1:0]   w_cap;
    logic               w_accept;
    logic               w_consume;
    logic               w_load_main;
    logic               w_load_skid;
    logic               w_skid_to_main;
    logic               w_m_rw;
    logic               w_m_mw;

    ex_mem_result_sel #(
        .DATA_W   (DATA_W),
        .RADDR_W  (RADDR_W),
        .LINK_DST (LINK_DST),
        .LINK_OFF (LINK_OFF)
    ) u_result_sel (
        .i_res_sel (ResSelE),
        .i_link_ra (LinkRaE),
        .i_pc4     (PC4E),
        .i_alu     (ALUResultE),
        .i_hi      (HiE),
        .i_lo      (LoE),
        .i_dst     (ExDstE),
        .o_result  (w_result),
        .o_dst     (w_dst)
    );

    assign w_cap = {RegWriteE, MemtoRegE, MemWriteE, w_result, ExMidE,
                    w_dst, LsE, SsE, PC4E};

    assign w_accept  = InValid & r_in_ready;
    assign w_consume = r_out_valid & OutReady;

    always_comb begin
        w_state_nxt    = r_state;
        w_load_main    = 1'b0;
        w_load_skid    = 1'b0;
        w_skid_to_main = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = ST_ONE;
                    w_load_main = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_accept && w_consume) begin
                    w_load_main = 1'b1;
                end else if (w_accept) begin
                    w_state_nxt = ST_FULL;
                    w_load_skid = 1'b1;
                end else if (w_consume) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_consume) begin
                    w_state_nxt    = ST_ONE;
                    w_skid_to_main = 1'b1;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
        // squash overrides everything, including a same-cycle accept
        if (Flush) begin
            w_state_nxt    = ST_EMPTY;
            w_load_main    = 1'b0;
            w_load_skid    = 1'b0;
            w_skid_to_main = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt != ST_FULL);
            r_out_valid <= (w_state_nxt != ST_EMPTY);
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_main) begin
                r_main <= w_cap;
            end else if (w_skid_to_main) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_cap;
            end
        end
    end

    assign {w_m_rw, MemtoRegM, w_m_mw, ResultM, ExMidM, ExDstM, LsM, SsM, PC4M} = r_main;

    assign InReady   = r_in_ready;
    assign OutValid  = r_out_valid;
    assign RegWriteM = w_m_rw & r_out_valid;
    assign MemWriteM = w_m_mw & r_out_valid;

endmodule

// File: doc/ex_mem_pipe_reg.md
Name: ex_mem_pipe_reg

Overview:
Parametrised EX→MEM pipeline stage register with a valid/ready handshake and a 2-entry skid buffer, so MEM back-pressure does not create a combinational ready path into EX. Performs EX-side result selection (ALU / LO / HI / link address) and link-destination override at capture. Supports flush for branch/exception squash. Sits between the ALU/MD unit and data memory; generalised successor of the fixed 32-bit EX/MEM latch.

Parameters:
DATA_W, 32, datapath width (ALU result, store data, HI/LO, PC).
RADDR_W, 5, register-file address width.
LS_W, 3, load-size/sign control width.
SS_W, 2, store-size control width.
LINK_REG, 31, destination register forced for link-to-ra instructions.
LINK_OFF, 4, added to PC4E to form the link value (PC+8).

Ports:
Clk  in  1  clock, rising edge.
Rst_n  in  1  asynchronous active-low reset.
Flush  in  1  squash all held entries; drop same-cycle input.
InValid  in  1  EX presents an instruction.
InReady  out  1  stage accepts; registered (= skid entry empty).
RegWriteE  in  1  register write enable.
MemtoRegE  in  1  writeback from memory.
MemWriteE  in  1  store enable.
ResSelE  in  2  00 ALU, 01 LO, 10 HI, 11 link.
LinkRaE  in  1  force destination to LINK_REG.
PC4E  in  DATA_W  PC+4 of the EX instruction.
ALUResultE  in  DATA_W  ALU output.
ExMidE  in  DATA_W  forwarded store data.
ExDstE  in  RADDR_W  destination register.
LsE  in  LS_W  load control.
SsE  in  SS_W  store control.
HiE, LoE  in  DATA_W  multiply/divide results.
OutValid  out  1  MEM-side entry valid.
OutReady  in  1  MEM consumes.
RegWriteM, MemtoRegM, MemWriteM  out  1  control; RegWriteM/MemWriteM forced 0 when OutValid=0.
ResultM  out  DATA_W  selected result.
ExMidM  out  DATA_W  store data.
ExDstM  out  RADDR_W  final destination.
LsM  out  LS_W; SsM  out  SS_W; PC4M  out  DATA_W.

Behaviour:
- Capture formation (combinational, on input): Result = ResSel 11 → PC4E+LINK_OFF (mod 2^DATA_W); 10 → HiE; 01 → LoE; 00 → ALUResultE. Dst = LinkRaE ? LINK_REG : ExDstE. No X-sensitive compares; all selects are exhaustive case.
- Storage: main entry (drives outputs) and skid entry, each with valid bit.
- States: EMPTY (main 0, skid 0), ONE (main 1, skid 0), FULL (main 1, skid 1). InReady = !skid_valid, a flop.
- Accept = InValid & InReady; consume = OutValid & OutReady.
- EMPTY: accept → ONE, load main.
- ONE: accept & consume → ONE, main reloaded; accept only → FULL, load skid; consume only → EMPTY.
- FULL: InReady=0; consume → ONE, skid moves to main; else hold.
- Latency: one cycle from accept to OutValid when main empty or being consumed.
- Ordering strictly FIFO; no entry lost or duplicated.
- Flush (sync, highest priority): next edge both valids 0, InReady 1, state EMPTY; same-cycle accept discarded; payload regs may keep stale data but gated controls read 0.
- Reset (async, Rst_n=0): valids 0, InReady 1, all payload and outputs 0; takes effect mid-transfer immediately. Release synchronous to Clk by the reset synchroniser upstream.
- OutReady=1 permanently with InValid=1 permanently: one instruction per cycle, never enters FULL.

Decomposition:
- Shared package: ResSel encodings (RES_ALU, RES_LO, RES_HI, RES_LINK), DATA_W/RADDR_W defaults, LINK_REG constant.
- One sub-module natural: ex_mem_result_sel (combinational result/destination formation); storage/FSM stays in the top.

Test Plan:
- Reset: Rst_n=0 mid-stream → OutValid=0, RegWriteM=0, ResultM=0, InReady=1 within the same cycle.
- Result select: PC4E=0x00400010, ResSel=11, LinkRaE=1, ExDstE=5 → ResultM=0x00400014, ExDstM=31; ResSel=10, HiE=0xDEADBEEF → ResultM=0xDEADBEEF; ResSel=01, LoE=0x12345678 → ResultM=0x12345678.
- Back-pressure: OutReady=0, send A,B → FULL, InReady=0, C stalled; OutReady=1 → A, B, C emerge in order, one per cycle.
- Streaming: OutReady=1, 8 back-to-back inputs → 8 outputs, 1-cycle latency, InReady never drops.
- Flush in FULL with InValid=1 → next cycle OutValid=0, MemWriteM=0, InReady=1; flushed and same-cycle inputs never appear.
- Wrap: PC4E=0xFFFFFFFC, ResSel=11 → ResultM=0x00000000.
